stopwatch_controller: RTL and testbench

Timekeeping and sequencing controller for the stopwatch. Turns debounced single-cycle button pulses (start/stop, lap, clear) into a run/pause/lap state machine. Runs a clock-driven seconds prescaler and a minutes:seconds counter. Drives the binary minutes and seconds buses consumed by seven_segment_driver, freezing the displayed value during lap hold while timing continues underneath.

---
 rtl/stopwatch_controller.sv | 137 +++++++++++++
 tb/tb_stopwatch_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing: run/pause/lap FSM, seconds prescaler and a saturating min:sec counter.
// Every output is a register; the display shows the lap capture while in lap hold.
module stopwatch_controller #(
   parameter int unsigned CLOCKS_PER_SECOND = 50000000,
   parameter int unsigned MAX_MINUTES       = 99
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic [6:0] minutes,
   output logic [6:0] seconds,
   output logic       running,
   output logic       lap_active,
   output logic       overflow,
   output logic       sec_tick
);

   localparam int unsigned PscW = (CLOCKS_PER_SECOND > 1) ? $clog2(CLOCKS_PER_SECOND) : 1;
   localparam logic [PscW-1:0] PscLast = PscW'(CLOCKS_PER_SECOND - 1);
   localparam logic [6:0] MaxMin = 7'(MAX_MINUTES);

   typedef enum logic [1:0] {StIdle, StRunning, StPaused, StLapHold} state_e;

   state_e          state_q, state_d;
   logic [PscW-1:0] psc_q, psc_d;
   logic [6:0]      min_q, min_d, sec_q, sec_d;
   logic [6:0]      lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;
   logic [6:0]      disp_min_d, disp_sec_d;
   logic            ovf_d, tick_d;
   logic            counting, wrap, saturate;

   always_comb begin
      state_d   = state_q;
      psc_d     = psc_q;
      min_d     = min_q;
      sec_d     = sec_q;
      lap_min_d = lap_min_q;
      lap_sec_d = lap_sec_q;
      ovf_d     = overflow;
      tick_d    = 1'b0;
      counting  = (state_q == StRunning) || (state_q == StLapHold);
      wrap      = counting && (psc_q == PscLast);
      saturate  = wrap && (sec_q == 7'd59) && (min_q >= MaxMin);

      if (counting) psc_d = wrap ? '0 : psc_q + PscW'(1);

      if (wrap) begin
         if (sec_q < 7'd59) begin
            sec_d  = sec_q + 7'd1;
            tick_d = 1'b1;
         end else if (!saturate) begin
            sec_d  = 7'd0;
            min_d  = min_q + 7'd1;
            tick_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      case (state_q)
         StIdle: begin
            if (start_stop) begin
               state_d = StRunning;
               psc_d   = '0;
            end
         end
         StRunning: begin
            if (start_stop) begin
               state_d = StPaused;
            end else if (lap) begin
               // Capture the pre-edge count; a coincident tick only moves the live count.
               state_d   = StLapHold;
               lap_min_d = min_q;
               lap_sec_d = sec_q;
            end
         end
         StLapHold: begin
            if (start_stop)  state_d = StPaused;
            else if (lap)    state_d = StRunning;
         end
         StPaused: begin
            if (start_stop && !overflow) state_d = StRunning;
         end
         default: state_d = StIdle;
      endcase

      if (saturate) state_d = StPaused;

      if (clear) begin
         state_d   = StIdle;
         psc_d     = '0;
         min_d     = 7'd0;
         sec_d     = 7'd0;
         lap_min_d = 7'd0;
         lap_sec_d = 7'd0;
         ovf_d     = 1'b0;
         tick_d    = 1'b0;
      end

      // Display is a registered copy of the current count, so it trails the count by a cycle.
      disp_min_d = (state_q == StLapHold) ? lap_min_q : min_q;
      disp_sec_d = (state_q == StLapHold) ? lap_sec_q : sec_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         psc_q      <= '0;
         min_q      <= 7'd0;
         sec_q      <= 7'd0;
         lap_min_q  <= 7'd0;
         lap_sec_q  <= 7'd0;
         minutes    <= 7'd0;
         seconds    <= 7'd0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         overflow   <= 1'b0;
         sec_tick   <= 1'b0;
      end else begin
         state_q    <= state_d;
         psc_q      <= psc_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         lap_min_q  <= lap_min_d;
         lap_sec_q  <= lap_sec_d;
         minutes    <= disp_min_d;
         seconds    <= disp_sec_d;
         running    <= (state_d == StRunning) || (state_d == StLapHold);
         lap_active <= (state_d == StLapHold);
         overflow   <= ovf_d;
         sec_tick   <= tick_d;
      end
   end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with 4 clocks per second and a 1-minute ceiling.
// Table vectors plus hand sequences feed expectations through a scoreboard queue.
module tb_stopwatch_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start_stop = 1'b0;
   logic       lap = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] minutes, seconds;
   logic       running, lap_active, overflow, sec_tick;

   stopwatch_controller #(
      .CLOCKS_PER_SECOND(4),
      .MAX_MINUTES      (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start_stop(start_stop),
      .lap       (lap),
      .clear     (clear),
      .minutes   (minutes),
      .seconds   (seconds),
      .running   (running),
      .lap_active(lap_active),
      .overflow  (overflow),
      .sec_tick  (sec_tick)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ss, lp, clr, rst;
      int unsigned n;
      int unsigned emin, esec;
      logic        er, el, eo, et;
   } vec_t;

   typedef struct {
      int          id;
      int unsigned m, s;
      logic        r, l, o, t;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mk(logic ss, logic lp, logic clr, logic rst, int unsigned n,
                               int unsigned emin, int unsigned esec,
                               logic er, logic el, logic eo, logic et);
      vec_t v;
      v.ss = ss; v.lp = lp; v.clr = clr; v.rst = rst; v.n = n;
      v.emin = emin; v.esec = esec; v.er = er; v.el = el; v.eo = eo; v.et = et;
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(logic ss, logic lp, logic clr, logic rst);
      start_stop = ss; lap = lp; clear = clr; reset = rst;
      step();
      start_stop = 1'b0; lap = 1'b0; clear = 1'b0; reset = 1'b0;
   endtask

   task automatic cmp(string nm, int id, int unsigned act, int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s id=%0d got=%0d want=%0d", nm, id, act, exp);
      end
   endtask

   task automatic push(int id, int unsigned m, int unsigned s, logic r, logic l, logic o,
                       logic t);
      exp_t e;
      e.id = id; e.m = m; e.s = s; e.r = r; e.l = l; e.o = o; e.t = t;
      sbq.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty got=0 want=1");
         return;
      end
      e = sbq.pop_front();
      cmp("minutes", e.id, 32'(minutes), e.m);
      cmp("seconds", e.id, 32'(seconds), e.s);
      cmp("running", e.id, 32'(running), 32'(e.r));
      cmp("lap_active", e.id, 32'(lap_active), 32'(e.l));
      cmp("overflow", e.id, 32'(overflow), 32'(e.o));
      cmp("sec_tick", e.id, 32'(sec_tick), 32'(e.t));
   endtask

   initial begin
      vec_t vecs[28];
      int unsigned c;

      //             ss    lp    clr   rst   n    min sec  run   lap   ovf   tick
      vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 0,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   0,  0, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 20,  0,  5, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10,  0,  5, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   0,  5, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1,   0,  5, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0,   0,  6, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2,   0,  6, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 0,   0,  7, 1'b1, 1'b1, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10,  0,  7, 1'b1, 1'b1, 1'b0, 1'b1);
      vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 0,   0,  7, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 0,   0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 13,  0,  3, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 3,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,   0,  0, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 0,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 0,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[20] = mk(1'b1, 1'b0, 1'b0, 1'b0, 241, 1,  0, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 238, 1, 59, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[22] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5,   1, 59, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[23] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[24] = mk(1'b1, 1'b0, 1'b0, 1'b0, 169, 0, 42, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[25] = mk(1'b0, 1'b1, 1'b0, 1'b0, 0,   0, 42, 1'b1, 1'b1, 1'b0, 1'b0);
      vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b1, 0,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[27] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4,   0,  0, 1'b1, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 28; i++) begin
         push(i, vecs[i].emin, vecs[i].esec, vecs[i].er, vecs[i].el, vecs[i].eo, vecs[i].et);
         pulse(vecs[i].ss, vecs[i].lp, vecs[i].clr, vecs[i].rst);
         for (int k = 0; k < int'(vecs[i].n); k++) step();
         pop_check();
      end

      // Free-running after restart: tick every 4th counting edge, display one edge behind.
      c = 4;
      for (int k = 0; k < 12; k++) begin
         c++;
         push(100 + k, 0, (c - 1) / 4, 1'b1, 1'b0, 1'b0, (c % 4) == 0);
         step();
         pop_check();
      end

      // Lap on a tick edge: capture takes the pre-edge count (0:04), live count moves to 0:05.
      step(); step(); step();
      push(200, 0, 4, 1'b1, 1'b1, 1'b0, 1'b1);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      pop_check();
      push(201, 0, 4, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step();
      pop_check();
      // Leave lap hold via start_stop: paused, display back to live 0:06 next cycle.
      push(202, 0, 6, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      pop_check();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
